wb_scoreboard: RTL
==================

Name: wb_scoreboard

Overview:
Writeback stage directly downstream of the ALU. It merges ALU writebacks, which have no backpressure, with load writebacks from the LSU, which use a valid/ready handshake, into one register-file write port. It also keeps a per-register pending-write scoreboard that the IDU uses for RAW/WAW hazard stalls, including against multi-cycle mul/div results.

Parameters:
LSU_FIFO_DEPTH, 2, LSU writeback buffer entries (power of 2, >=2)
CNT_W, 2, width of per-register pending counter (max in-flight writes per rd = 2^CNT_W-1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
iss_vld  in  1  IDU issues an instruction that writes a register
iss_rd  in  5  destination of issued instruction
iss_stall  out  1  issue refused: counter of iss_rd saturated
alu_wb_vld  in  1  ALU result valid (no ready)
alu_wb_addr  in  5  ALU destination
alu_wb_data  in  64  ALU result
lsu_wb_vld  in  1  LSU load result valid
lsu_wb_rdy  out  1  buffer can accept
lsu_wb_addr  in  5  LSU destination
lsu_wb_data  in  64  LSU load data
rf_we  out  1  register-file write enable
rf_waddr  out  5  register-file write address
rf_wdata  out  64  register-file write data
rs1_addr  in  5  hazard query 1
rs2_addr  in  5  hazard query 2
rs1_busy  out  1  rs1 has pending write
rs2_busy  out  1  rs2 has pending write
sb_err  out  1  sticky: commit to register with zero pending count

Behaviour:
- Reset (rst_n=0 at posedge): all counters 0, FIFO empty, sb_err=0. Resulting outputs: rf_we=0, lsu_wb_rdy=1, rs*_busy=0, iss_stall=0.
- Reset mid-operation discards buffered LSU data; no write is emitted.
- LSU FIFO:
  - Enqueue when lsu_wb_vld & lsu_wb_rdy.
  - lsu_wb_rdy = !full (registered state only; does not look ahead at same-cycle dequeue).
  - Pointers are CNT-free binary and wrap modulo LSU_FIFO_DEPTH.
  - Full and empty are distinguished by an extra pointer bit.
- Commit arbitration (combinational outputs):
  - If alu_wb_vld: rf_we=1 with ALU addr/data. ALU has fixed priority.
  - Else if FIFO non-empty: rf_we=1 with FIFO head; dequeue at the clock edge.
  - Else rf_we=0.
  - rf_waddr/rf_wdata are 0 when rf_we=0.
- Writes to x0:
  - Never asserted on rf_we and never counted.
  - LSU entries with addr 0 are still enqueued and consumed; the commit cycle is spent but rf_we=0.
- Latency:
  - ALU commit in the same cycle it is valid.
  - LSU commit earliest 1 cycle after the enqueue handshake.
  - LSU data can starve indefinitely under continuous ALU traffic; upstream guarantees gaps.
- Scoreboard: 31 counters of CNT_W bits (x1..x31).
  - inc = iss_vld & !iss_stall & iss_rd!=0
  - dec = commit to register r (r!=0)
  - inc and dec on the same r in one cycle: counter unchanged.
  - Different registers update independently.
  - iss_stall = iss_vld & iss_rd!=0 & cnt[iss_rd]==max. A same-cycle dec does not lift the stall.
  - dec with cnt==0: counter stays 0, sb_err set until reset.
- Busy outputs:
  - rsN_busy = cnt[rsN_addr]!=0 (registered state, no same-cycle forwarding).
  - Always 0 for addr 0.
  - Ordering of multiple writes to the same rd is the producer's responsibility; the counter only tracks quantity.

Decomposition:
- Shared package: wb_src_e enum (WB_NONE, WB_ALU, WB_LSU); constants NUM_ARCH_REGS=32 and XLEN=64, reused by ALU/IDU.
- One sub-module: wb_fifo, a generic synchronous FIFO with parameters WIDTH and DEPTH, instantiated with WIDTH=69 (addr+data).
- Arbitration and scoreboard live in the top.

Test Plan:
- Reset, then idle: rf_we=0, lsu_wb_rdy=1, rs1_busy=0 for rs1_addr=5, sb_err=0.
- Issue rd=5 at cycle 0 -> rs1_busy(5)=1 from cycle 1. ALU wb addr=5 data=0xDEAD at cycle 3 -> rf_we=1 waddr=5 wdata=0xDEAD at cycle 3; busy=0 from cycle 4.
- LSU wb addr=7 data=0x11 and ALU wb addr=8 data=0x22 in the same cycle:
  - That cycle: ALU commits.
  - Next cycle (ALU idle): LSU commits addr 7 data 0x11.
  - Both counters return to 0.
- ALU valid every cycle for 4 cycles while LSU sends 3 beats:
  - lsu_wb_rdy drops to 0 after 2 accepted.
  - Once ALU idles, the two buffered entries commit in FIFO order, then the third beat is accepted.
- Issue rd=9 three times (CNT_W=2) -> 4th issue gets iss_stall=1 and count stays 3. Issue and commit on rd=9 in the same cycle -> count unchanged.
- ALU wb addr=12 with no prior issue -> rf_we=1 and sb_err=1 from next cycle, count stays 0. ALU wb addr=0 -> rf_we=0, no sb_err.

Source files
------------

// File: rtl/wb_scoreboard_pkg.sv
// Shared writeback definitions: commit source, architectural sizes and the
// LSU writeback entry layout buffered between the LSU and the register file.
package wb_scoreboard_pkg;

    localparam int NUM_ARCH_REGS = 32;
    localparam int XLEN          = 64;
    localparam int REG_ADDR_W    = $clog2(NUM_ARCH_REGS);

    // Which producer owns the register-file write port in a given cycle.
    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LSU
    } wb_src_e;

    // One buffered load writeback: destination plus data (69 bits).
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    localparam int WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO. Binary read/write pointers carry one extra bit so
// that full and empty can be told apart when the index bits match.
module wb_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[IDX_W-1:0]];

    // Next pointer values; wrap falls out of the natural binary overflow.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Pointer registers; reset empties the FIFO and discards its contents.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so all registers sample the same edge.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
        if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/wb_scoreboard.sv
// Writeback stage: merges ALU results (fixed priority, no backpressure) with
// buffered LSU load results onto one register-file write port, and tracks a
// per-register count of in-flight writes for IDU hazard detection.
import wb_scoreboard_pkg::*;

module wb_scoreboard #(
    parameter int LSU_FIFO_DEPTH = 2,
    parameter int CNT_W          = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iss_vld,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    output logic                  iss_stall,
    input  logic                  alu_wb_vld,
    input  logic [REG_ADDR_W-1:0] alu_wb_addr,
    input  logic [XLEN-1:0]       alu_wb_data,
    input  logic                  lsu_wb_vld,
    output logic                  lsu_wb_rdy,
    input  logic [REG_ADDR_W-1:0] lsu_wb_addr,
    input  logic [XLEN-1:0]       lsu_wb_data,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    wb_entry_t             lsu_in;
    wb_entry_t             lsu_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;

    wb_src_e               commit_src;
    logic [REG_ADDR_W-1:0] commit_addr;
    logic [XLEN-1:0]       commit_data;

    logic [CNT_W-1:0]      cnt_q [NUM_ARCH_REGS];
    logic [CNT_W-1:0]      cnt_d [NUM_ARCH_REGS];
    logic                  sb_err_q, sb_err_d;
    logic                  inc_en;
    logic                  dec_en;

    assign lsu_in.addr = lsu_wb_addr;
    assign lsu_in.data = lsu_wb_data;

    wb_fifo #(
        .WIDTH (WB_ENTRY_W),
        .DEPTH (LSU_FIFO_DEPTH)
    ) u_lsu_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (lsu_wb_vld),
        .wdata_i (lsu_in),
        .pop_i   (fifo_pop),
        .rdata_o (lsu_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Ready reflects only the registered fill level, never a same-cycle pop.
    assign lsu_wb_rdy = !fifo_full;

    // Commit arbitration: ALU first, then FIFO head; nothing commits in reset.
    always_comb begin
        commit_src  = WB_NONE;
        commit_addr = '0;
        commit_data = '0;
        if (rst_n) begin
            if (alu_wb_vld) begin
                commit_src  = WB_ALU;
                commit_addr = alu_wb_addr;
                commit_data = alu_wb_data;
            end else if (!fifo_empty) begin
                commit_src  = WB_LSU;
                commit_addr = lsu_head.addr;
                commit_data = lsu_head.data;
            end
        end
    end

    // An x0 entry still consumes its commit slot, it just never reaches the RF.
    assign fifo_pop = (commit_src == WB_LSU);
    assign rf_we    = (commit_src != WB_NONE) && (commit_addr != '0);
    assign rf_waddr = rf_we ? commit_addr : '0;
    assign rf_wdata = rf_we ? commit_data : '0;

    // A saturated counter refuses the issue even if that register commits now.
    assign iss_stall = iss_vld && (iss_rd != '0) && (cnt_q[iss_rd] == CNT_MAX);
    assign inc_en    = iss_vld && !iss_stall && (iss_rd != '0);
    assign dec_en    = (commit_src != WB_NONE) && (commit_addr != '0);

    // Per-register counter update; issue and commit to one register cancel out.
    always_comb begin
        logic inc_r;
        logic dec_r;
        inc_r    = 1'b0;
        dec_r    = 1'b0;
        cnt_d    = cnt_q;
        sb_err_d = sb_err_q;
        for (int r = 1; r < NUM_ARCH_REGS; r++) begin
            inc_r = inc_en && (iss_rd == REG_ADDR_W'(r));
            dec_r = dec_en && (commit_addr == REG_ADDR_W'(r));
            if (inc_r && !dec_r) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec_r && !inc_r) begin
                if (cnt_q[r] == '0) sb_err_d = 1'b1;
                else                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    // Scoreboard state: counters and the sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_ARCH_REGS; r++) cnt_q[r] <= '0;
            sb_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err   = sb_err_q;
    assign rs1_busy = (rs1_addr != '0) && (cnt_q[rs1_addr] != '0);
    assign rs2_busy = (rs2_addr != '0) && (cnt_q[rs2_addr] != '0);

endmodule
